// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor: 2-bit saturating counter states.
package bp_pkg;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

endpackage

// File: rtl/bp_if.sv
// Fetch-lookup, MEM-training and statistics signals of the branch predictor.
// Handshake: no ready/valid pairing; upd_valid qualifies the upd_* bundle for exactly one cycle.
interface bp_if #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 16
);
    logic [XLEN-1:0]   if_pc;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_pc;
    logic              upd_valid;
    logic [XLEN-1:0]   upd_pc;
    logic              upd_taken;
    logic [XLEN-1:0]   upd_target;
    logic              upd_pred_taken;
    logic [XLEN-1:0]   upd_pred_pc;
    logic              mispredict;
    logic [XLEN-1:0]   redirect_pc;
    logic [STAT_W-1:0] branch_count;
    logic [STAT_W-1:0] miss_count;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_pc,
        input  pred_taken, pred_pc, mispredict, redirect_pc, branch_count, miss_count
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_pc,
        output pred_taken, pred_pc, mispredict, redirect_pc, branch_count, miss_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next state of a 2-bit saturating branch counter given the resolved outcome.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i && ctr_i != CTR_ST) begin
            ctr_o = ctr_i + 2'd1;
        end else if (!taken_i && ctr_i != CTR_SNT) begin
            ctr_o = ctr_i - 2'd1;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF lookup, registered MEM training,
// combinational mispredict/redirect and saturating branch/mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 6,
    parameter int STAT_W  = 16
) (
    input logic clock,
    input logic clear,
    bp_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [XLEN-1:0]   target_q [ENTRIES];
    logic [STAT_W-1:0] branch_count_q, branch_count_d;
    logic [STAT_W-1:0] miss_count_q, miss_count_d;

    logic [IDX_W-1:0]  if_idx, upd_idx;
    logic [TAG_W-1:0]  if_tag, upd_tag;
    logic              if_hit, upd_hit, upd_write;
    logic [1:0]        ctr_next, ctr_d;
    logic [XLEN-1:0]   redirect;
    logic              miss;
    logic              unused_pred_taken;

    assign if_idx  = bus.if_pc[IDX_W-1:0];
    assign if_tag  = bus.if_pc[IDX_W+TAG_W-1:IDX_W];
    assign upd_idx = bus.upd_pc[IDX_W-1:0];
    assign upd_tag = bus.upd_pc[IDX_W+TAG_W-1:IDX_W];

    // Lookup reads the registered table, so a same-cycle update is not visible until next cycle.
    assign if_hit          = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign bus.pred_taken  = if_hit && ctr_q[if_idx][1];
    assign bus.pred_pc     = bus.pred_taken ? target_q[if_idx] : bus.if_pc + 1'b1;

    assign redirect        = (bus.upd_valid && bus.upd_taken) ? bus.upd_target : bus.upd_pc + 1'b1;
    assign miss            = bus.upd_valid && (redirect != bus.upd_pred_pc);
    assign bus.mispredict  = miss;
    assign bus.redirect_pc = redirect;

    // The carried direction bit is implied by upd_pred_pc and is not needed for training.
    assign unused_pred_taken = bus.upd_pred_taken;

    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_write = bus.upd_valid && (upd_hit || bus.upd_taken);

    sat_counter2 u_sat_counter2 (
        .ctr_i   (ctr_q[upd_idx]),
        .taken_i (bus.upd_taken),
        .ctr_o   (ctr_next)
    );

    assign ctr_d = upd_hit ? ctr_next : CTR_ALLOC;

    always_comb begin
        branch_count_d = branch_count_q;
        miss_count_d   = miss_count_q;
        if (bus.upd_valid && branch_count_q != '1) branch_count_d = branch_count_q + 1'b1;
        if (miss && miss_count_q != '1)            miss_count_d   = miss_count_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= CTR_RESET;
                target_q[i] <= '0;
            end
            branch_count_q <= '0;
            miss_count_q   <= '0;
        end else begin
            if (upd_write) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
                ctr_q[upd_idx]   <= ctr_d;
                if (bus.upd_taken) target_q[upd_idx] <= bus.upd_target;
            end
            branch_count_q <= branch_count_d;
            miss_count_q   <= miss_count_d;
        end
    end

    assign bus.branch_count = branch_count_q;
    assign bus.miss_count   = miss_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (16 entries, 6-bit tags) plus a 2-bit-statistics instance.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bp_if #(.XLEN(32), .STAT_W(16)) bus ();
    bp_if #(.XLEN(32), .STAT_W(2))  bus2 ();

    branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(6), .STAT_W(16)) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(6), .STAT_W(2)) dut2 (
        .clock (clk),
        .clear (clear),
        .bus   (bus2.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic [31:0] ppc);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_taken      = taken;
        bus.upd_target     = tgt;
        bus.upd_pred_taken = (ppc != pc + 32'd1);
        bus.upd_pred_pc    = ppc;
    endtask

    task automatic idle();
        bus.upd_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input logic exp_taken, input logic [31:0] exp_pc,
                        input string tag);
        bus.if_pc = pc;
        settle();
        chk({tag, "_taken"}, {31'd0, bus.pred_taken}, {31'd0, exp_taken});
        chk({tag, "_pc"}, bus.pred_pc, exp_pc);
    endtask

    task automatic stats(input int exp_b, input int exp_m, input string tag);
        chk({tag, "_branches"}, {16'd0, bus.branch_count}, exp_b);
        chk({tag, "_misses"}, {16'd0, bus.miss_count}, exp_m);
    endtask

    initial begin
        clear = 1'b1;
        bus.if_pc = '0; bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_taken = 0;
        bus.upd_target = '0; bus.upd_pred_taken = 0; bus.upd_pred_pc = '0;
        bus2.if_pc = '0; bus2.upd_valid = 0; bus2.upd_pc = 32'h1; bus2.upd_taken = 1;
        bus2.upd_target = 32'h8; bus2.upd_pred_taken = 0; bus2.upd_pred_pc = 32'h0;
        tick();
        clear = 1'b0;

        // 1: reset state
        look(32'h20, 1'b0, 32'h21, "rst_lookup");
        stats(0, 0, "rst");
        settle();
        chk("idle_mispredict", {31'd0, bus.mispredict}, 32'd0);
        chk("idle_redirect", bus.redirect_pc, 32'h1);

        // 2: first taken allocates; lookup in the same cycle still sees the old entry
        upd(32'h20, 1'b1, 32'h08, 32'h21);
        settle();
        chk("alloc_mispredict", {31'd0, bus.mispredict}, 32'd1);
        chk("alloc_redirect", bus.redirect_pc, 32'h08);
        chk("alloc_same_cycle", {31'd0, bus.pred_taken}, 32'd0);
        tick(); idle();
        look(32'h20, 1'b1, 32'h08, "alloc_after");
        stats(1, 1, "alloc");

        // 3: not taken twice -> 01 then 00
        upd(32'h20, 1'b0, 32'h08, 32'h08);
        settle();
        chk("nt1_mispredict", {31'd0, bus.mispredict}, 32'd1);
        chk("nt1_redirect", bus.redirect_pc, 32'h21);
        tick(); idle();
        look(32'h20, 1'b0, 32'h21, "nt1_after");
        upd(32'h20, 1'b0, 32'h08, 32'h21);
        settle();
        chk("nt2_mispredict", {31'd0, bus.mispredict}, 32'd0);
        tick(); idle();
        look(32'h20, 1'b0, 32'h21, "nt2_after");
        stats(3, 2, "nt2");

        // taken three times: 00 -> 01 -> 10 -> 11
        upd(32'h20, 1'b1, 32'h08, 32'h21); tick(); idle();
        look(32'h20, 1'b0, 32'h21, "t1_after");
        upd(32'h20, 1'b1, 32'h08, 32'h21); tick(); idle();
        look(32'h20, 1'b1, 32'h08, "t2_after");
        upd(32'h20, 1'b1, 32'h08, 32'h08);
        settle();
        chk("t3_mispredict", {31'd0, bus.mispredict}, 32'd0);
        tick();
        // 4th taken saturates at 11 and rewrites the target
        upd(32'h20, 1'b1, 32'h0C, 32'h08); tick(); idle();
        look(32'h20, 1'b1, 32'h0C, "t4_after");
        // one not-taken from 11 must still predict taken
        upd(32'h20, 1'b0, 32'h0C, 32'h0C); tick(); idle();
        look(32'h20, 1'b1, 32'h0C, "sat_check");
        stats(8, 6, "sat");

        // 4: alias on index 0 evicts 0x20
        upd(32'h30, 1'b1, 32'h04, 32'h31); tick(); idle();
        look(32'h20, 1'b0, 32'h21, "alias_old");
        look(32'h30, 1'b1, 32'h04, "alias_new");
        // tag miss, not taken: table untouched
        upd(32'h40, 1'b0, 32'h99, 32'h41);
        settle();
        chk("ntmiss_mispredict", {31'd0, bus.mispredict}, 32'd0);
        tick(); idle();
        look(32'h30, 1'b1, 32'h04, "ntmiss_keep");
        look(32'h40, 1'b0, 32'h41, "ntmiss_noalloc");
        stats(10, 7, "alias");

        // 5: same-cycle lookup and allocate on index 5
        bus.if_pc = 32'h25;
        upd(32'h25, 1'b1, 32'h10, 32'h26);
        settle();
        chk("coll_same_cycle", {31'd0, bus.pred_taken}, 32'd0);
        chk("coll_same_pc", bus.pred_pc, 32'h26);
        tick(); idle();
        look(32'h25, 1'b1, 32'h10, "coll_next");

        // PC wrap at all-ones
        bus.upd_pc = 32'hFFFF_FFFF;
        look(32'hFFFF_FFFF, 1'b0, 32'h0, "wrap_lookup");
        chk("wrap_redirect", bus.redirect_pc, 32'h0);

        // 6: clear coincident with an allocating update
        clear = 1'b1;
        upd(32'h50, 1'b1, 32'h07, 32'h51);
        settle();
        chk("clr_comb_mispredict", {31'd0, bus.mispredict}, 32'd1);
        tick(); idle();
        clear = 1'b0;
        look(32'h50, 1'b0, 32'h51, "clr_noalloc");
        look(32'h25, 1'b0, 32'h26, "clr_wipe25");
        look(32'h30, 1'b0, 32'h31, "clr_wipe30");
        stats(0, 0, "clr");

        // 2-bit statistics saturate at 3
        bus2.upd_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus2.upd_valid = 1'b0;
        settle();
        chk("stat2_misses", {30'd0, bus2.miss_count}, 32'd3);
        chk("stat2_branches", {30'd0, bus2.branch_count}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
